// File: rtl/gfx_clip_responder.sv
// Pixel write responder: clips rasterizer pixels against the clip rectangle and render target,
// forwards survivors with a linear offset. Optional counters under GFX_CLIP_RESPONDER_STATS_EN.
`timescale 1ns/1ps

module gfx_clip_responder #(
    parameter int unsigned point_width  = 16,
    parameter int unsigned offset_width = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    write_i,
    output logic                    ack_o,
    input  logic [point_width-1:0]  x_i,
    input  logic [point_width-1:0]  y_i,
    input  logic [point_width-1:0]  u_i,
    input  logic [point_width-1:0]  v_i,

    input  logic                    clipping_enable_i,
    input  logic [point_width-1:0]  clip_pixel0_x_i,
    input  logic [point_width-1:0]  clip_pixel0_y_i,
    input  logic [point_width-1:0]  clip_pixel1_x_i,
    input  logic [point_width-1:0]  clip_pixel1_y_i,
    input  logic [point_width-1:0]  target_size_x_i,
    input  logic [point_width-1:0]  target_size_y_i,

    output logic                    write_o,
    input  logic                    ack_i,
    output logic [point_width-1:0]  x_o,
    output logic [point_width-1:0]  y_o,
    output logic [point_width-1:0]  u_o,
    output logic [point_width-1:0]  v_o,
    output logic [offset_width-1:0] pixel_offset_o,
`ifdef GFX_CLIP_RESPONDER_STATS_EN
    input  logic                    stats_clear_i,
    output logic [31:0]             pixels_written_o,
    output logic [31:0]             pixels_discarded_o,
`endif
    output logic                    busy_o
);

    localparam int unsigned ProdWidth = 2 * point_width;
    localparam int unsigned SumWidth  = ProdWidth + 1;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StFwd,
        StAck
    } state_e;

    state_e                  r_state;
    logic                    r_inside;
    logic                    r_ack;
    logic                    r_write;
    logic                    r_busy;
    logic [point_width-1:0]  r_x;
    logic [point_width-1:0]  r_y;
    logic [point_width-1:0]  r_u;
    logic [point_width-1:0]  r_v;
    logic [offset_width-1:0] r_offset;

    logic                    w_in_target;
    logic                    w_in_clip;
    logic                    w_inside;
    logic [ProdWidth-1:0]    w_product;
    logic [SumWidth-1:0]     w_sum;
    logic [offset_width-1:0] w_offset;

    assign w_in_target = (x_i < target_size_x_i) & (y_i < target_size_y_i);
    assign w_in_clip   = (x_i >= clip_pixel0_x_i) & (x_i < clip_pixel1_x_i) &
                         (y_i >= clip_pixel0_y_i) & (y_i < clip_pixel1_y_i);
    assign w_inside    = w_in_target & (~clipping_enable_i | w_in_clip);

    // Full-width product and sum, then resized to the offset width.
    assign w_product = {{point_width{1'b0}}, r_y} * {{point_width{1'b0}}, target_size_x_i};
    assign w_sum     = {1'b0, w_product} + {{(point_width + 1){1'b0}}, r_x};
    assign w_offset  = offset_width'(w_sum);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_inside <= 1'b0;
            r_ack    <= 1'b0;
            r_write  <= 1'b0;
            r_busy   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_u      <= '0;
            r_v      <= '0;
            r_offset <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (write_i) begin
                        r_x      <= x_i;
                        r_y      <= y_i;
                        r_u      <= u_i;
                        r_v      <= v_i;
                        r_inside <= w_inside;
                        r_busy   <= 1'b1;
                        r_state  <= StEval;
                    end
                end
                StEval: begin
                    r_offset <= w_offset;
                    if (r_inside) begin
                        r_write <= 1'b1;
                        r_state <= StFwd;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                    end
                end
                StFwd: begin
                    if (ack_i) begin
                        r_write <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                    end
                end
                StAck: begin
                    // write_i is not sampled here; the rasterizer advances on this edge.
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ack_o          = r_ack;
    assign write_o        = r_write;
    assign busy_o         = r_busy;
    assign x_o            = r_x;
    assign y_o            = r_y;
    assign u_o            = r_u;
    assign v_o            = r_v;
    assign pixel_offset_o = r_offset;

`ifdef GFX_CLIP_RESPONDER_STATS_EN
    logic        w_inc_written;
    logic        w_inc_discarded;
    logic [31:0] r_written;
    logic [31:0] r_discarded;

    assign w_inc_written   = (r_state == StFwd) & ack_i;
    assign w_inc_discarded = (r_state == StEval) & ~r_inside;

    // Clear takes priority over a same-cycle increment; counters saturate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_written   <= '0;
            r_discarded <= '0;
        end else if (stats_clear_i) begin
            r_written   <= '0;
            r_discarded <= '0;
        end else begin
            if (w_inc_written && (r_written != 32'hFFFF_FFFF)) begin
                r_written <= r_written + 32'd1;
            end
            if (w_inc_discarded && (r_discarded != 32'hFFFF_FFFF)) begin
                r_discarded <= r_discarded + 32'd1;
            end
        end
    end

    assign pixels_written_o   = r_written;
    assign pixels_discarded_o = r_discarded;
`endif

endmodule
